// File: rtl/ann_pkg.sv
// Shared definitions for the ANN memory read path: node counts, counter
// widths, layer encoding, sequencer states and the per-layer burst lengths.
package ann_pkg;

  localparam int ANN_INPUT_NODES    = 2;
  localparam int ANN_HIDDEN_1_NODES = 32;
  localparam int ANN_HIDDEN_2_NODES = 32;
  localparam int ANN_OUTPUT_NODES   = 3;

  localparam int DATA_COUNTER_WIDTH   = $clog2(ANN_HIDDEN_1_NODES);
  localparam int WEIGHT_COUNTER_WIDTH = 11;

  // Layer encoding: 0 = input, 1/2 = hidden, 3 = output
  localparam int LAYER_INPUT    = 0;
  localparam int LAYER_HIDDEN_1 = 1;
  localparam int LAYER_HIDDEN_2 = 2;
  localparam int LAYER_OUTPUT   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DATA,
    ST_RD_WEIGHT,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  // Burst lengths for one layer: activations of the previous layer, and
  // weights followed by biases of the target layer.
  typedef struct packed {
    logic [DATA_COUNTER_WIDTH:0]   n_prev;
    logic [WEIGHT_COUNTER_WIDTH:0] n_w;
  } burst_len_t;

  function automatic int layer_nodes(input int layer, input int n_in, input int n_h1,
                                     input int n_h2, input int n_out);
    case (layer)
      LAYER_INPUT:    return n_in;
      LAYER_HIDDEN_1: return n_h1;
      LAYER_HIDDEN_2: return n_h2;
      LAYER_OUTPUT:   return n_out;
      default:        return 0;
    endcase
  endfunction

  function automatic burst_len_t burst_lengths(input int layer, input int n_in, input int n_h1,
                                               input int n_h2, input int n_out);
    burst_len_t r;
    int         n_prev;
    int         n_cur;
    n_prev   = layer_nodes(layer - 1, n_in, n_h1, n_h2, n_out);
    n_cur    = layer_nodes(layer, n_in, n_h1, n_h2, n_out);
    r.n_prev = (DATA_COUNTER_WIDTH+1)'(n_prev);
    r.n_w    = (WEIGHT_COUNTER_WIDTH+1)'(n_prev * n_cur + n_cur);
    return r;
  endfunction

endpackage

// File: rtl/ann_burst_counter.sv
// Address generator for one RAM burst: issues one registered read per
// non-stalled run cycle and flags the final address of the burst.
module ann_burst_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          run,
  input  logic          stall,
  input  logic [CW:0]   len,
  output logic          en,
  output logic [CW-1:0] addr,
  output logic          last
);

  logic [CW-1:0] cnt;
  logic          issue;

  assign issue = run && !stall;
  // Final address is issued this cycle; the counter then holds instead of wrapping
  assign last  = issue && ({1'b0, cnt} == len - 1'b1);

  // Registered request: enable pulses per issue, address holds across stalls
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt  <= '0;
      en   <= 1'b0;
      addr <= '0;
    end else begin
      en <= issue;
      if (issue) begin
        addr <= cnt;
        if (!last) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ann_memory_read_sequencer.sv
// Read-side controller for ann_memory: per layer, bursts the previous
// layer's activations, then the layer's weights+biases, then waits for all
// returns before pulsing done to the layer scheduler.
module ann_memory_read_sequencer
  import ann_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = ANN_INPUT_NODES,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = ANN_HIDDEN_1_NODES,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = ANN_HIDDEN_2_NODES,
  parameter int NUMBER_OF_OUTPUT_NODE         = ANN_OUTPUT_NODES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic [LAYER_WIDTH-1:0]          i_layer,
  input  logic                            i_stall,
  input  logic                            i_data_valid,
  input  logic                            i_weight_valid,
  output logic                            o_ram_data_enable,
  output logic                            o_rw_data_select,
  output logic [LAYER_WIDTH-1:0]          o_data_layer,
  output logic [DATA_COUNTER_WIDTH-1:0]   o_data_addr,
  output logic                            o_ram_weight_enable,
  output logic                            o_rw_weight_select,
  output logic [LAYER_WIDTH-1:0]          o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error
);

  // Port widths come from the package; reject configurations they cannot hold
  if (DATA_WIDTH < 1 || LAYER_WIDTH < 2 ||
      $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1) != DATA_COUNTER_WIDTH) begin : g_bad_cfg
    $error("ann_memory_read_sequencer: unsupported width configuration");
  end

  seq_state_t                    state;
  burst_len_t                    req_len;
  logic [DATA_COUNTER_WIDTH:0]   n_prev_q, data_rx, data_len;
  logic [WEIGHT_COUNTER_WIDTH:0] n_w_q, weight_rx;
  logic                          accept, data_run, data_last, weight_run, weight_last, clr;

  assign req_len = burst_lengths(int'(i_layer), NUMBER_OF_INPUT_NODE,
                                 NUMBER_OF_HIDDEN_NODE_LAYER_1,
                                 NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);

  // The first activation read issues on the accept edge, so the data burst
  // runs from the lookup before the lengths have been latched.
  assign accept     = (state == ST_IDLE) && i_start && (i_layer != LAYER_WIDTH'(LAYER_INPUT));
  assign data_run   = accept || (state == ST_RD_DATA);
  assign data_len   = (state == ST_IDLE) ? req_len.n_prev : n_prev_q;
  assign weight_run = (state == ST_RD_WEIGHT);
  assign clr        = (state == ST_DONE);

  ann_burst_counter #(.CW(DATA_COUNTER_WIDTH)) u_data_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .run   (data_run),
    .stall (i_stall),
    .len   (data_len),
    .en    (o_ram_data_enable),
    .addr  (o_data_addr),
    .last  (data_last)
  );

  ann_burst_counter #(.CW(WEIGHT_COUNTER_WIDTH)) u_weight_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .run   (weight_run),
    .stall (i_stall),
    .len   (n_w_q),
    .en    (o_ram_weight_enable),
    .addr  (o_weight_addr),
    .last  (weight_last)
  );

  // Sequencer FSM with return counting and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_error            <= 1'b0;
      o_rw_data_select   <= 1'b0;
      o_rw_weight_select <= 1'b0;
      o_data_layer       <= '0;
      o_weight_layer     <= '0;
      n_prev_q           <= '0;
      n_w_q              <= '0;
      data_rx            <= '0;
      weight_rx          <= '0;
    end else begin
      o_rw_data_select   <= 1'b1;
      o_rw_weight_select <= 1'b1;
      o_done             <= 1'b0;
      o_error            <= 1'b0;
      // Returns saturate at the expected count so stray valids cannot overrun
      if (state != ST_IDLE) begin
        if (i_data_valid && (data_rx < n_prev_q))    data_rx   <= data_rx + 1'b1;
        if (i_weight_valid && (weight_rx < n_w_q))   weight_rx <= weight_rx + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_layer == LAYER_WIDTH'(LAYER_INPUT)) begin
              o_error <= 1'b1;
            end else begin
              n_prev_q       <= req_len.n_prev;
              n_w_q          <= req_len.n_w;
              o_data_layer   <= i_layer - 1'b1;
              o_weight_layer <= i_layer;
              o_busy         <= 1'b1;
              state          <= data_last ? ST_RD_WEIGHT : ST_RD_DATA;
            end
          end
        end
        ST_RD_DATA:   if (data_last)   state <= ST_RD_WEIGHT;
        ST_RD_WEIGHT: if (weight_last) state <= ST_DRAIN;
        ST_DRAIN: begin
          if ((data_rx == n_prev_q) && (weight_rx == n_w_q)) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          data_rx   <= '0;
          weight_rx <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ann_memory_read_sequencer.sv
// Bench for ann_memory_read_sequencer: a count-based behavioural model is
// stepped on every rising edge, the driver/checker compares every output on
// the falling edge, and a delay-line RAM stand-in returns valids.
module tb_ann_memory_read_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, i_start, i_stall, i_data_valid, i_weight_valid;
  logic [1:0]  i_layer;
  logic        o_ram_data_enable, o_rw_data_select, o_ram_weight_enable, o_rw_weight_select;
  logic [1:0]  o_data_layer, o_weight_layer;
  logic [4:0]  o_data_addr;
  logic [10:0] o_weight_addr;
  logic        o_busy, o_done, o_error;

  ann_memory_read_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_start             (i_start),
    .i_layer             (i_layer),
    .i_stall             (i_stall),
    .i_data_valid        (i_data_valid),
    .i_weight_valid      (i_weight_valid),
    .o_ram_data_enable   (o_ram_data_enable),
    .o_rw_data_select    (o_rw_data_select),
    .o_data_layer        (o_data_layer),
    .o_data_addr         (o_data_addr),
    .o_ram_weight_enable (o_ram_weight_enable),
    .o_rw_weight_select  (o_rw_weight_select),
    .o_weight_layer      (o_weight_layer),
    .o_weight_addr       (o_weight_addr),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_error             (o_error)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  logic        mv = 1'b0;
  logic        m_active = 1'b0, m_fin = 1'b0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_rw = 1'b0, m_den = 1'b0, m_wen = 1'b0;
  logic [1:0]  m_dlayer = '0, m_wlayer = '0;
  int          m_daddr = 0, m_waddr = 0;
  int          np = 0, nw = 0, d_iss = 0, w_iss = 0, d_rx = 0, w_rx = 0;

  function automatic int nodes(input int l);
    case (l)
      0: return 2;
      1: return 32;
      2: return 32;
      3: return 3;
      default: return 0;
    endcase
  endfunction

  // Work is tracked as "reads issued" and "words returned"; one read per
  // unstalled edge, activations before weights, done once everything issued
  // earlier has also returned.
  initial forever begin
    @(posedge clk);
    cyc++;
    m_den = 1'b0; m_wen = 1'b0; m_done = 1'b0; m_err = 1'b0;
    if (!rst_n) begin
      mv = 1'b1; m_active = 1'b0; m_fin = 1'b0; m_busy = 1'b0; m_rw = 1'b0;
      m_dlayer = '0; m_wlayer = '0;
    end else begin
      m_rw = 1'b1;
      if (m_fin) begin
        m_fin = 1'b0;
      end else if (!m_active) begin
        if (i_start) begin
          if (i_layer == 2'd0) m_err = 1'b1;
          else begin
            np = nodes(int'(i_layer) - 1);
            nw = np * nodes(int'(i_layer)) + nodes(int'(i_layer));
            m_active = 1'b1; m_busy = 1'b1;
            m_dlayer = i_layer - 2'd1; m_wlayer = i_layer;
            d_iss = 0; w_iss = 0; d_rx = 0; w_rx = 0;
            if (!i_stall) begin m_den = 1'b1; m_daddr = 0; d_iss = 1; end
          end
        end
      end else if (d_iss == np && w_iss == nw && d_rx == np && w_rx == nw) begin
        m_done = 1'b1; m_busy = 1'b0; m_active = 1'b0; m_fin = 1'b1;
      end else begin
        if (i_data_valid && d_rx < np)   d_rx++;
        if (i_weight_valid && w_rx < nw) w_rx++;
        if (!i_stall) begin
          if (d_iss < np)      begin m_den = 1'b1; m_daddr = d_iss; d_iss++; end
          else if (w_iss < nw) begin m_wen = 1'b1; m_waddr = w_iss; w_iss++; end
        end
      end
    end
  end

  // ---------------- checker / driver ----------------
  int total = 0, bad = 0;
  int den_cnt = 0, wen_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int done_at = 0, busy_at = 0, lat = 2;
  logic busy_prev = 1'b0;
  logic [31:0] dpipe = '0, wpipe = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mv) begin
      chk("busy", 32'(o_busy), 32'(m_busy));
      chk("done", 32'(o_done), 32'(m_done));
      chk("error", 32'(o_error), 32'(m_err));
      chk("data_en", 32'(o_ram_data_enable), 32'(m_den));
      chk("weight_en", 32'(o_ram_weight_enable), 32'(m_wen));
      chk("rw_data", 32'(o_rw_data_select), 32'(m_rw));
      chk("rw_weight", 32'(o_rw_weight_select), 32'(m_rw));
      chk("data_layer", 32'(o_data_layer), 32'(m_dlayer));
      chk("weight_layer", 32'(o_weight_layer), 32'(m_wlayer));
      if (m_den) chk("data_addr", 32'(o_data_addr), 32'(m_daddr));
      if (m_wen) chk("weight_addr", 32'(o_weight_addr), 32'(m_waddr));
    end
    if (o_ram_data_enable)   den_cnt++;
    if (o_ram_weight_enable) wen_cnt++;
    if (o_error)             err_cnt++;
    if (o_busy)              busy_cnt++;
    if (o_done) begin done_cnt++; done_at = cyc; end
    if (o_busy && !busy_prev) busy_at = cyc;
    busy_prev = o_busy;
    // RAM stand-in: each read comes back valid lat cycles after it is seen
    dpipe = {dpipe[30:0], o_ram_data_enable};
    wpipe = {wpipe[30:0], o_ram_weight_enable};
    i_data_valid   = dpipe[lat];
    i_weight_valid = wpipe[lat];
  endtask

  task automatic wait_waddr(input int a, input int budget, input string tag);
    int n = 0;
    while (!(o_ram_weight_enable && int'(o_weight_addr) == a) && n < budget) begin
      tick(); n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL %s: weight address %0d not seen within %0d cycles", tag, a, budget);
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    int base;
    base = done_cnt;
    while (done_cnt == base && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL %s: no done within %0d cycles", tag, budget);
    end
  endtask

  task automatic start(input logic [1:0] layer);
    i_start = 1'b1; i_layer = layer;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  int d0, w0, n0, e0, b0;

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_layer = 2'd0; i_stall = 1'b0;
    i_data_valid = 1'b0; i_weight_valid = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_data_en", 32'(o_ram_data_enable), 0);
    chk("rst_weight_en", 32'(o_ram_weight_enable), 0);
    chk("rst_rw_data", 32'(o_rw_data_select), 0);
    chk("rst_weight_addr", 32'(o_weight_addr), 0);
    chk("rst_done_err", 32'({o_done, o_error}), 0);
    rst_n = 1'b1;
    tick();

    // Layer 1, latency 2
    d0 = den_cnt; w0 = wen_cnt; n0 = done_cnt;
    start(2'd1);
    chk("l1_first_data_en", 32'(o_ram_data_enable), 1);
    chk("l1_first_data_addr", 32'(o_data_addr), 0);
    wait_done(400, "l1_wait_done");
    repeat (3) tick();
    chk("l1_data_reads", 32'(den_cnt - d0), 2);
    chk("l1_weight_reads", 32'(wen_cnt - w0), 96);
    chk("l1_done_pulses", 32'(done_cnt - n0), 1);
    chk("l1_done_latency", 32'(done_at - busy_at), 101);
    chk("l1_data_layer", 32'(o_data_layer), 0);
    chk("l1_weight_layer", 32'(o_weight_layer), 1);

    // Layer 2 with a 3-cycle stall at weight address 500
    d0 = den_cnt; w0 = wen_cnt; n0 = done_cnt;
    start(2'd2);
    wait_waddr(500, 700, "l2_wait_500");
    i_stall = 1'b1;
    repeat (3) begin
      tick();
      chk("l2_stall_en", 32'(o_ram_weight_enable), 0);
      chk("l2_stall_addr", 32'(o_weight_addr), 500);
    end
    i_stall = 1'b0;
    wait_done(1500, "l2_wait_done");
    repeat (3) tick();
    chk("l2_data_reads", 32'(den_cnt - d0), 32);
    chk("l2_weight_reads", 32'(wen_cnt - w0), 1056);
    chk("l2_done_pulses", 32'(done_cnt - n0), 1);
    chk("l2_done_latency", 32'(done_at - busy_at), 1094);

    // Illegal layer 0
    d0 = den_cnt; w0 = wen_cnt; e0 = err_cnt; b0 = busy_cnt;
    start(2'd0);
    chk("l0_error_now", 32'(o_error), 1);
    repeat (4) tick();
    chk("l0_error_pulses", 32'(err_cnt - e0), 1);
    chk("l0_busy_cycles", 32'(busy_cnt - b0), 0);
    chk("l0_reads", 32'((den_cnt - d0) + (wen_cnt - w0)), 0);

    // Layer 3, latency 7, repeated starts, spurious weight valids
    lat = 7;
    d0 = den_cnt; w0 = wen_cnt; n0 = done_cnt; e0 = err_cnt;
    start(2'd3);
    repeat (5) tick();
    start(2'd1);
    wait_waddr(50, 200, "l3_wait_50");
    start(2'd0);
    wait_waddr(98, 200, "l3_wait_98");
    repeat (7) tick();
    repeat (5) begin tick(); i_weight_valid = 1'b1; end
    repeat (12) tick();
    chk("l3_data_reads", 32'(den_cnt - d0), 32);
    chk("l3_weight_reads", 32'(wen_cnt - w0), 99);
    chk("l3_done_pulses", 32'(done_cnt - n0), 1);
    chk("l3_done_latency", 32'(done_at - busy_at), 139);
    chk("l3_no_error", 32'(err_cnt - e0), 0);
    lat = 2;
    repeat (10) tick();

    // Reset during the layer 1 weight burst, then a clean rerun
    n0 = done_cnt;
    start(2'd1);
    wait_waddr(40, 100, "rst_wait_40");
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_weight_en", 32'(o_ram_weight_enable), 0);
    chk("mid_rst_weight_addr", 32'(o_weight_addr), 0);
    chk("mid_rst_layers", 32'({o_data_layer, o_weight_layer}), 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_rst_no_done", 32'(done_cnt - n0), 0);
    d0 = den_cnt; w0 = wen_cnt;
    start(2'd1);
    wait_done(400, "rerun_wait_done");
    repeat (3) tick();
    chk("rerun_reads", 32'((den_cnt - d0) + (wen_cnt - w0)), 98);
    chk("rerun_done_pulses", 32'(done_cnt - n0), 1);
    chk("rerun_done_latency", 32'(done_at - busy_at), 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
